// File: rtl/prbs_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prbs_burst_ctrl: frames a PRBS generator's bit stream into counted       |
// | bursts separated by idle gaps. Optional macro: PRBS_ERR_INJ_EN. Rev 1.0  |
// +--------------------------------------------------------------------------+
module prbs_burst_ctrl #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [7:0]       burst_num,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             gen_dout_vld,
  input  logic             gen_dout,
`ifdef PRBS_ERR_INJ_EN
  input  logic             err_inj,
`endif
  output logic             prbs_en,
  output logic             tx_vld,
  output logic             tx_data,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [31:0]      bits_sent
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    GAP   = 3'd3,
    FLUSH = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] len_q, len_m1, en_cnt, rx_cnt;
  logic [7:0]       num_q, burst_cnt;
  logic [GAP_W-1:0] gap_q, gap_m1, gap_cnt;
  logic             flush_low;
  logic             accept, active, abort_req, rx_bit, last_rx;
  logic             burst_end, seq_done, flush_exit, tx_vld_n, flip;

  assign len_m1  = len_q - CNT_W'(1);
  assign gap_m1  = gap_q - GAP_W'(1);
  assign prbs_en = (state == RUN);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    burst_end  = 1'b0;
    seq_done   = 1'b0;
    flush_exit = 1'b0;
    active     = (state == RUN) || (state == DRAIN) || (state == GAP);
    abort_req  = stop && active;
    rx_bit     = gen_dout_vld && ((state == RUN) || (state == DRAIN));
    last_rx    = rx_bit && (rx_cnt == len_m1);
    tx_vld_n   = rx_bit && !abort_req;
    case (state)
      IDLE: begin
        if (start && !stop && (burst_len != '0)) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (abort_req)              state_n = FLUSH;
        else if (en_cnt == len_m1)  state_n = DRAIN;
      end
      DRAIN: begin
        if (abort_req) begin
          state_n = FLUSH;
        end else if (last_rx) begin
          burst_end = 1'b1;
          // Continuous mode (burst_num==0) never compares the burst counter.
          if ((num_q != 8'd0) && ((burst_cnt + 8'd1) == num_q)) begin
            seq_done = 1'b1;
            state_n  = IDLE;
          end else if (gap_q != '0) begin
            state_n = GAP;
          end else begin
            state_n = RUN;
          end
        end
      end
      GAP: begin
        if (abort_req)               state_n = FLUSH;
        else if (gap_cnt == gap_m1)  state_n = RUN;
      end
      FLUSH: begin
        if (!gen_dout_vld && flush_low) begin
          flush_exit = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      num_q     <= '0;
      gap_q     <= '0;
      en_cnt    <= '0;
      rx_cnt    <= '0;
      burst_cnt <= '0;
      gap_cnt   <= '0;
      flush_low <= 1'b0;
      tx_vld    <= 1'b0;
      tx_data   <= 1'b0;
      tx_sof    <= 1'b0;
      tx_eof    <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      bits_sent <= '0;
    end else begin
      tx_vld  <= tx_vld_n;
      tx_data <= tx_vld_n & (gen_dout ^ flip);
      tx_sof  <= tx_vld_n && (rx_cnt == '0);
      tx_eof  <= tx_vld_n && last_rx;
      done    <= seq_done;
      aborted <= flush_exit;

      en_cnt    <= (state == RUN) ? en_cnt + CNT_W'(1) : '0;
      gap_cnt   <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
      flush_low <= (state == FLUSH) && !gen_dout_vld;

      if (((state != RUN) && (state != DRAIN)) || burst_end) rx_cnt <= '0;
      else if (rx_bit)                                       rx_cnt <= rx_cnt + CNT_W'(1);

      if (accept) begin
        len_q     <= burst_len;
        num_q     <= burst_num;
        gap_q     <= gap_len;
        burst_cnt <= '0;
        bits_sent <= '0;
      end else begin
        if (burst_end) burst_cnt <= burst_cnt + 8'd1;
        if (tx_vld_n && (bits_sent != 32'hFFFF_FFFF)) bits_sent <= bits_sent + 32'd1;
      end
    end
  end

`ifdef PRBS_ERR_INJ_EN
  logic err_pend;

  assign flip = err_pend && tx_vld_n;

  // A request arriving while one is still pending is dropped, not queued.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   err_pend <= 1'b0;
    else if (state_n == IDLE)   err_pend <= 1'b0;
    else if (flip)              err_pend <= 1'b0;
    else if (err_inj)           err_pend <= 1'b1;
  end
`else
  assign flip = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_prbs_burst_ctrl: scoreboard bench with a PRBS7 generator model.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_prbs_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] burst_len = '0;
  logic [7:0]  burst_num = '0;
  logic [7:0]  gap_len = '0;
  logic        gen_dout_vld = 1'b0;
  logic        gen_dout = 1'b0;
  logic        prbs_en, tx_vld, tx_data, tx_sof, tx_eof, busy, done, aborted;
  logic [31:0] bits_sent;
`ifdef PRBS_ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  bit sb_off = 1'b0;
  logic [2:0] sbq[$];
  logic [6:0] gold = 7'h7F;
  logic [6:0] gen_lfsr = 7'h7F;
  logic       gen_v1 = 1'b0;
  logic       gen_d1 = 1'b0;

  prbs_burst_ctrl #(.CNT_W(16), .GAP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .burst_len(burst_len), .burst_num(burst_num), .gap_len(gap_len),
    .gen_dout_vld(gen_dout_vld), .gen_dout(gen_dout),
`ifdef PRBS_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .prbs_en(prbs_en), .tx_vld(tx_vld), .tx_data(tx_data), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .busy(busy), .done(done), .aborted(aborted), .bits_sent(bits_sent)
  );

  always #5 clk = ~clk;

  // Generator model: valid and data appear two cycles after prbs_en.
  always @(posedge clk) begin
    if (prbs_en) begin
      gen_d1   <= gen_lfsr[6] ^ gen_lfsr[5];
      gen_lfsr <= {gen_lfsr[5:0], gen_lfsr[6] ^ gen_lfsr[5]};
    end
    gen_v1       <= prbs_en;
    gen_dout_vld <= gen_v1;
    gen_dout     <= gen_d1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit sof, input bit eof, input bit flip);
    logic b;
    b    = gold[6] ^ gold[5];
    gold = {gold[5:0], b};
    sbq.push_back({b ^ flip, sof, eof});
  endtask

  task automatic pulse_start(input int len, input int num, input int gap);
    burst_len = 16'(len);
    burst_num = 8'(num);
    gap_len   = 8'(gap);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Monitor: pops one expectation per presented tx bit.
  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      if (done)    done_cnt++;
      if (aborted) abort_cnt++;
      if (tx_vld && !sb_off) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: got data/sof/eof=%b expected no tx bit", {tx_data, tx_sof, tx_eof});
        end else begin
          e = sbq.pop_front();
          if ({tx_data, tx_sof, tx_eof} !== e) begin
            failures++;
            $display("FAIL tx_bit: got data/sof/eof=%b expected %b", {tx_data, tx_sof, tx_eof}, e);
          end
        end
      end
    end
  end

  // Runs one finite sequence; the prbs_en low stretch between bursts is the
  // two drain cycles plus the programmed gap.
  task automatic run_seq(input string tag, input int len, input int num, input int gap,
                         input int exp_en, input int exp_bits, input int exp_gaps, input int exp_low);
    int en_hi, first_en, first_tx, low, ngaps, bad_gap, d0;
    bit seen;
    for (int b = 0; b < exp_bits; b++) push_exp(b % len == 0, b % len == len - 1, 1'b0);
    d0 = done_cnt;
    pulse_start(len, num, gap);
    en_hi = 0; first_en = -1; first_tx = -1; low = 0; ngaps = 0; bad_gap = 0; seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (prbs_en) begin
        if (first_en < 0) first_en = c;
        if (seen && low > 0) begin
          ngaps++;
          if (low != exp_low) bad_gap++;
        end
        low = 0; seen = 1; en_hi++;
      end else if (seen) begin
        low++;
      end
      if (tx_vld && first_tx < 0) first_tx = c;
      if (done) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check({tag, "_en_cycles"}, en_hi, exp_en);
    check({tag, "_tx_latency"}, first_tx - first_en, 3);
    check({tag, "_gap_count"}, ngaps, exp_gaps);
    check({tag, "_gap_len_errors"}, bad_gap, 0);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_bits_sent"}, bits_sent, exp_bits);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_sb_left"}, sbq.size(), 0);
  endtask

  initial begin
    int txc, d0, a0, busy_seen;
    bit saw_tx;

    repeat (3) @(negedge clk);
    check("reset_outputs", {prbs_en, tx_vld, tx_data, tx_sof, tx_eof, busy, done, aborted}, 0);
    check("reset_bits_sent", bits_sent, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outputs", {prbs_en, tx_vld, busy, done, aborted}, 0);

    run_seq("single8", 8, 1, 0, 8, 8, 0, 2);
    run_seq("three4gap5", 4, 3, 5, 12, 12, 2, 7);
    run_seq("len1x2", 1, 2, 0, 2, 2, 1, 2);

`ifdef PRBS_ERR_INJ_EN
    // Bit 6 is the first tx bit captured after the pulse; the second cycle
    // of err_inj lands while the flag is pending.
    for (int b = 0; b < 32; b++) push_exp(b == 0, b == 31, b == 6);
    d0 = done_cnt;
    pulse_start(32, 1, 0);
    txc = 0;
    for (int c = 0; c < 100 && txc < 5; c++) begin
      @(negedge clk);
      if (tx_vld) txc++;
    end
    err_inj = 1'b1;
    repeat (2) @(negedge clk);
    err_inj = 1'b0;
    for (int c = 0; c < 100 && done_cnt == d0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("errinj_done", done_cnt - d0, 1);
    check("errinj_bits_sent", bits_sent, 32);
    check("errinj_sb_left", sbq.size(), 0);
`endif

    // Continuous mode, aborted after 40 tx bits.
    for (int b = 0; b < 40; b++) push_exp(b % 16 == 0, b % 16 == 15, 1'b0);
    d0 = done_cnt; a0 = abort_cnt;
    pulse_start(16, 0, 0);
    txc = 0;
    for (int c = 0; c < 400 && txc < 40; c++) begin
      @(negedge clk);
      if (tx_vld) txc++;
    end
    check("cont_tx_before_stop", txc, 40);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_prbs_en_off", prbs_en, 0);
    for (int c = 0; c < 30 && abort_cnt == a0; c++) @(negedge clk);
    check("stop_busy_falls", busy, 0);
    repeat (3) @(negedge clk);
    check("stop_aborted_pulses", abort_cnt - a0, 1);
    check("stop_no_done", done_cnt - d0, 0);
    check("stop_bits_sent", bits_sent, 40);
    check("stop_sb_left", sbq.size(), 0);

    // Corner cases that must leave the block idle.
    busy_seen = 0;
    pulse_start(0, 1, 0);
    for (int c = 0; c < 8; c++) begin
      if (busy || prbs_en) busy_seen++;
      @(negedge clk);
    end
    check("len0_stays_idle", busy_seen, 0);

    busy_seen = 0;
    burst_len = 16'd8; burst_num = 8'd1; gap_len = 8'd0;
    @(negedge clk); start = 1'b1; stop = 1'b1;
    @(negedge clk); start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (busy || prbs_en) busy_seen++;
      @(negedge clk);
    end
    check("start_stop_stays_idle", busy_seen, 0);

    // Asynchronous reset while bits are streaming.
    sb_off = 1'b1;
    saw_tx = 1'b0;
    pulse_start(8, 1, 0);
    for (int c = 0; c < 10 && !saw_tx; c++) begin
      @(negedge clk);
      if (tx_vld) saw_tx = 1'b1;
    end
    check("rst_mid_run_tx_seen", saw_tx, 1);
    d0 = done_cnt; a0 = abort_cnt;
    #1 rst = 1'b0;
    #1;
    check("rst_async_outputs", {prbs_en, tx_vld, tx_data, tx_sof, tx_eof, busy, done, aborted}, 0);
    check("rst_async_bits_sent", bits_sent, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    check("rst_idle_after", {busy, prbs_en, tx_vld}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/prbs_burst_ctrl.md
PRBS_BURST_CTRL -- requirements
Module: prbs_burst_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the burst-length and bit counters.
REQ-002 SHALL have parameter GAP_W, default 8, the width of the inter-burst gap counter.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a burst sequence.
REQ-006 stop  in  1  one-cycle abort request.
REQ-007 burst_len  in  CNT_W  valid bits per burst; sampled on start acceptance.
REQ-008 burst_num  in  8  number of bursts; 0 = continuous until stop; sampled on start acceptance.
REQ-009 gap_len  in  GAP_W  idle cycles between bursts; sampled on start acceptance.
REQ-010 gen_dout_vld  in  1  valid from the PRBS generator.
REQ-011 gen_dout  in  1  data bit from the PRBS generator.
REQ-012 prbs_en  out  1  enable to the PRBS generator.
REQ-013 tx_vld, tx_data, tx_sof, tx_eof  out  1 each  framed serial output: valid, bit, first bit of burst, last bit of burst.
REQ-014 busy  out  1  high whenever state is not IDLE.
REQ-015 done  out  1  one-cycle pulse on normal sequence completion.
REQ-016 aborted  out  1  one-cycle pulse when a stop-initiated flush completes.
REQ-017 bits_sent  out  32  count of tx_vld bits since the last accepted start.

Function
REQ-018 SHALL implement the states IDLE, RUN, DRAIN, GAP and FLUSH.
REQ-019 IDLE: start with burst_len!=0 and stop=0 SHALL latch the parameters, clear bits_sent and the burst counter, and enter RUN; otherwise start SHALL be ignored.
REQ-020 RUN: prbs_en=1 every cycle; when the enable counter reaches the latched burst_len, the state SHALL go to DRAIN, with prbs_en=0 from that cycle.
REQ-021 The generator's valid follows prbs_en by 2 cycles; the block SHALL register the output, so tx_vld follows gen_dout_vld by 1 cycle (3 cycles from prbs_en).
REQ-022 tx_vld/tx_data SHALL be registered copies of gen_dout_vld/gen_dout while in RUN or DRAIN; tx_vld SHALL be 0 in any other state.
REQ-023 tx_sof SHALL mark the valid bit with receive index 0; tx_eof SHALL mark index burst_len-1; when burst_len=1, both SHALL assert on the same bit.
REQ-024 DRAIN: once burst_len valid bits have been received, the burst SHALL end and the next state SHALL be:
- IDLE with done=1 if the bursts completed equal burst_num (burst_num!=0);
- otherwise GAP if gap_len!=0;
- otherwise RUN directly.
REQ-025 GAP: prbs_en=0 for exactly gap_len cycles, then RUN.
REQ-026 stop in RUN, DRAIN or GAP SHALL force prbs_en=0 in the next cycle and enter FLUSH; FLUSH SHALL suppress tx_vld, wait until gen_dout_vld has been low for 2 consecutive cycles, then enter IDLE with aborted=1 (no done).
REQ-027 stop in IDLE or FLUSH SHALL have no effect; start while busy SHALL be ignored; when start and stop coincide, stop SHALL win.
REQ-028 bits_sent SHALL increment on each tx_vld and saturate at 32'hFFFFFFFF.
REQ-029 In continuous mode the burst counter SHALL not be compared; the sequence SHALL end only by stop.
REQ-030 The generator's shift-register state SHALL not be touched; sequence continuity across bursts is preserved.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, clear all counters, and drive every output to 0.
REQ-032 Reset mid-burst SHALL drop prbs_en and tx_vld immediately, with no done or aborted pulse.

Configuration
REQ-033 With macro PRBS_ERR_INJ_EN defined:
- input err_inj (1 bit) SHALL exist;
- a pulse SHALL set a pending flag that inverts tx_data on the next tx_vld bit, then clears;
- err_inj while the flag is pending SHALL be ignored;
- the flag SHALL clear on reset or on entry to IDLE.
REQ-034 Without PRBS_ERR_INJ_EN, the err_inj port and the flag SHALL be absent, and tx_data SHALL be the unmodified gen_dout.

Verification
REQ-035 start, burst_len=8, burst_num=1, gap_len=0 -> prbs_en high 8 cycles; tx_vld 8 bits starting 3 cycles after first prbs_en; sof on bit 0, eof on bit 7; done once; bits_sent=8.
REQ-036 burst_len=4, burst_num=3, gap_len=5 -> 3 framed bursts of 4 bits; prbs_en low exactly 5 cycles in each GAP; bits_sent=12; single done.
REQ-037 burst_len=1, burst_num=2, gap_len=0 -> each tx bit has sof=eof=1; 2 bits total; done.
REQ-038 burst_num=0, burst_len=16; stop after 40 tx bits -> prbs_en low the next cycle; no tx_vld after stop; aborted pulse; no done; busy falls.
REQ-039 Corner cases:
- start with burst_len=0 -> remains IDLE;
- start and stop together -> remains IDLE;
- rst asserted mid-RUN -> all outputs 0 asynchronously.
REQ-040 With PRBS_ERR_INJ_EN: err_inj during a 32-bit burst -> exactly one tx bit differs from the golden PRBS sequence; a second err_inj while pending -> no extra flip.
